// File: rtl/decoder_pkg.sv
// Shared state encoding and sizing helpers for the registered one-hot pulse decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } stateT;

  localparam int DEFAULT_CODE_W = 2;

  function automatic int outWidth(input int codeW);
    return 1 << codeW;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that stops at zero; shared by the drive window and the idle gap.
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement, and the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Registered binary-to-one-hot decoder: each accepted code is driven for HOLD_CYCLES clocks,
// followed by GAP_CYCLES all-zero clocks, with a one-entry pending slot for the next code.
module decoder_2to4_pulse
  import decoder_pkg::*;
#(
  parameter int CODE_W      = DEFAULT_CODE_W,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 0,
  localparam int OUT_W      = outWidth(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_onehot,
  output logic [CODE_W-1:0] out_code,
  output logic              busy
);

  localparam int CNT_W = $clog2(maxInt(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  stateT             state;
  stateT             nextState;
  logic [CODE_W-1:0] activeCode;
  logic [CODE_W-1:0] nextCode;
  logic [CODE_W-1:0] pendCode;
  logic [CODE_W-1:0] nextPendCode;
  logic              pendVld;
  logic              nextPendVld;
  logic              timerLoad;
  logic              timerDec;
  logic              timerZero;
  logic [CNT_W-1:0]  timerValue;
  logic              transfer;
  logic [OUT_W-1:0]  decoded;

  assign in_ready = rst_n & ~pendVld;
  assign transfer = in_valid & in_ready;
  assign busy     = (state != IDLE) | pendVld;
  assign decoded  = OUT_W'(1) << nextCode;

  pulse_timer #(
    .W(CNT_W)
  ) uTimer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timerLoad),
    .value(timerValue),
    .dec  (timerDec),
    .zero (timerZero)
  );

  // A full pending slot always wins at window end; because in_ready is low while the slot
  // is full, a bypass of the incoming code can only happen with the slot empty.
  always_comb begin
    nextState    = state;
    nextCode     = activeCode;
    nextPendVld  = pendVld;
    nextPendCode = pendCode;
    timerLoad    = 1'b0;
    timerValue   = HOLD_LOAD;
    timerDec     = 1'b0;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          nextState = DRIVE;
          nextCode  = in_code;
          timerLoad = 1'b1;
        end
      end
      DRIVE, GAP: begin
        if (!timerZero) begin
          timerDec = 1'b1;
          if (transfer) begin
            nextPendVld  = 1'b1;
            nextPendCode = in_code;
          end
        end else if ((state == DRIVE) && (GAP_CYCLES > 0)) begin
          nextState  = GAP;
          timerLoad  = 1'b1;
          timerValue = GAP_LOAD;
          if (transfer) begin
            nextPendVld  = 1'b1;
            nextPendCode = in_code;
          end
        end else if (pendVld) begin
          nextState   = DRIVE;
          nextCode    = pendCode;
          nextPendVld = 1'b0;
          timerLoad   = 1'b1;
        end else if (transfer) begin
          nextState = DRIVE;
          nextCode  = in_code;
          timerLoad = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      activeCode <= '0;
      pendVld    <= 1'b0;
      pendCode   <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_code   <= '0;
    end else begin
      state      <= nextState;
      activeCode <= nextCode;
      pendVld    <= nextPendVld;
      pendCode   <= nextPendCode;
      out_valid  <= (nextState == DRIVE);
      out_onehot <= (nextState == DRIVE) ? decoded : '0;
      out_code   <= (nextState == DRIVE) ? nextCode : '0;
    end
  end

endmodule
